cmd_ram_ctrl: RTL and testbench

//  Command-driven single-port RAM behind a serial-to-parallel front end. Each rx_valid word is
//  a 2-bit opcode plus payload that sets the write address, writes data, sets the read address
//  or issues a read. Read data returns over a valid/ready handshake. Generalises the 8-bit/256-word

---
 rtl/cmd_ram_ctrl.sv | 133 +++++++++++++
 tb/tb_cmd_ram_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cmd_ram_ctrl.sv
// Command-driven single-port RAM: opcode+payload words set addresses, write and read; read data on valid/ready.
// Optional CMD_RAM_AUTOINC_EN: accepted WRITE/READ post-increment their address, wrapping at MEM_DEPTH-1.
module cmd_ram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH+1:0] din,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  err
);

    typedef enum logic [1:0] {
        OP_SET_WADDR = 2'b00,
        OP_WRITE     = 2'b01,
        OP_SET_RADDR = 2'b10,
        OP_READ      = 2'b11
    } op_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [0:MEM_DEPTH-1];

    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_tx_valid;
    logic                  r_err;

    op_t                   w_op;
    logic [DATA_WIDTH-1:0] w_payload;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_addr_ok;
    logic [ADDR_WIDTH-1:0] w_wr_addr_next;
    logic [ADDR_WIDTH-1:0] w_rd_addr_next;
    logic                  w_tx_valid_next;
    logic                  w_err_next;
    logic                  w_wr_en;
    logic                  w_rd_en;

    assign w_op      = op_t'(din[DATA_WIDTH+1:DATA_WIDTH]);
    assign w_payload = din[DATA_WIDTH-1:0];
    assign w_addr    = w_payload[ADDR_WIDTH-1:0];
    // Zero-extended compare so a full power-of-two depth never rejects
    assign w_addr_ok = ({1'b0, w_addr} < DEPTH_EXT);

`ifdef CMD_RAM_AUTOINC_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    function automatic logic [ADDR_WIDTH-1:0] inc_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
    endfunction
`endif

    always_comb begin
        w_wr_addr_next  = r_wr_addr;
        w_rd_addr_next  = r_rd_addr;
        w_tx_valid_next = r_tx_valid & ~tx_ready;
        w_err_next      = 1'b0;
        w_wr_en         = 1'b0;
        w_rd_en         = 1'b0;
        if (rx_valid) begin
            case (w_op)
                OP_SET_WADDR: begin
                    if (w_addr_ok) w_wr_addr_next = w_addr;
                    else           w_err_next     = 1'b1;
                end
                OP_WRITE: begin
                    w_wr_en = 1'b1;
`ifdef CMD_RAM_AUTOINC_EN
                    w_wr_addr_next = inc_addr(r_wr_addr);
`endif
                end
                OP_SET_RADDR: begin
                    if (w_addr_ok) w_rd_addr_next = w_addr;
                    else           w_err_next     = 1'b1;
                end
                OP_READ: begin
                    // A held, unconsumed result blocks a new read
                    if (!r_tx_valid || tx_ready) begin
                        w_rd_en         = 1'b1;
                        w_tx_valid_next = 1'b1;
`ifdef CMD_RAM_AUTOINC_EN
                        w_rd_addr_next  = inc_addr(r_rd_addr);
`endif
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_tx_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wr_addr  <= w_wr_addr_next;
            r_rd_addr  <= w_rd_addr_next;
            r_tx_valid <= w_tx_valid_next;
            r_err      <= w_err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_wr_en) begin
            r_mem[r_wr_addr] <= w_payload;
        end
    end

    // Registered read port with resettable output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dout <= '0;
        end else if (w_rd_en) begin
            r_dout <= r_mem[r_rd_addr];
        end
    end

    assign dout     = r_dout;
    assign tx_valid = r_tx_valid;
    assign err      = r_err;

endmodule

// File: tb/tb_cmd_ram_ctrl.sv
// Directed bench for cmd_ram_ctrl (MEM_DEPTH=200); expected read data is queued at issue and popped on output.
module tb_cmd_ram_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 200;

    localparam logic [1:0] OP_SW = 2'b00;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_SR = 2'b10;
    localparam logic [1:0] OP_RD = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW+1:0] din;
    logic          rx_valid;
    logic [DW-1:0] dout;
    logic          tx_valid;
    logic          tx_ready;
    logic          err;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    cmd_ram_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .rx_valid(rx_valid),
        .dout    (dout),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .err     (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("[TB] %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One command per cycle; outputs are sampled 1 ns after the edge
    task automatic cmd(input logic [1:0] op, input logic [DW-1:0] payload, input logic ready);
        din      = {op, payload};
        rx_valid = 1'b1;
        tx_ready = ready;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        din      = '0;
    endtask

    task automatic idle(input logic ready);
        rx_valid = 1'b0;
        tx_ready = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic issue_read(input logic [DW-1:0] exp, input logic ready);
        exp_q.push_back(exp);
        cmd(OP_RD, '0, ready);
    endtask

    task automatic expect_out(input string tag);
        logic [DW-1:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed empty-scoreboard expected queued read", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".valid"}, 32'(tx_valid), 32'd1);
            check({tag, ".dout"}, 32'(dout), 32'(e));
        end
    endtask

    initial begin
        logic [DW-1:0] exp_w1;
        logic [DW-1:0] exp_w2;

        rst_n    = 1'b0;
        din      = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;

        // 1. reset held for two clocks
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rst.dout", 32'(dout), 32'h0);
        check("rst.valid", 32'(tx_valid), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // 2. basic write/read, handshake clears valid
        cmd(OP_SW, 8'h10, 1'b1);
        cmd(OP_WR, 8'hA5, 1'b1);
        cmd(OP_SR, 8'h10, 1'b1);
        issue_read(8'hA5, 1'b1);
        expect_out("basic");
        check("basic.err", 32'(err), 32'd0);
        idle(1'b1);
        check("basic.clear", 32'(tx_valid), 32'd0);
        check("basic.hold_dout", 32'(dout), 32'hA5);

        // 3. back-pressure: second READ rejected, err for one cycle
        cmd(OP_SW, 8'h03, 1'b0);
        cmd(OP_WR, 8'h11, 1'b0);
        cmd(OP_SR, 8'h03, 1'b0);
        issue_read(8'h11, 1'b0);
        expect_out("stall1");
        cmd(OP_RD, '0, 1'b0);
        check("stall.err", 32'(err), 32'd1);
        check("stall.dout", 32'(dout), 32'h11);
        check("stall.valid", 32'(tx_valid), 32'd1);
        idle(1'b0);
        check("stall.err_pulse", 32'(err), 32'd0);
        check("stall.valid_held", 32'(tx_valid), 32'd1);
        idle(1'b1);
        check("stall.clear", 32'(tx_valid), 32'd0);

        // 4. range check on depth 200
        cmd(OP_SR, 8'h03, 1'b1);
        check("range.ok_err", 32'(err), 32'd0);
        cmd(OP_SR, 8'hC8, 1'b1);
        check("range.raddr_err", 32'(err), 32'd1);
        issue_read(8'h11, 1'b1);
        expect_out("range.keep");
        check("range.err_clear", 32'(err), 32'd0);
        cmd(OP_SW, 8'hC8, 1'b1);
        check("range.waddr_err", 32'(err), 32'd1);
        cmd(OP_SR, 8'hC7, 1'b1);
        check("range.last_ok", 32'(err), 32'd0);
        idle(1'b1);

        // WRITE then READ of the same address on the next cycle
        cmd(OP_SW, 8'h05, 1'b1);
        cmd(OP_SR, 8'h05, 1'b1);
        cmd(OP_WR, 8'h5A, 1'b1);
        issue_read(8'h5A, 1'b1);
        expect_out("wr_rd");
        idle(1'b1);

        // 5. two writes/reads from the last address
`ifdef CMD_RAM_AUTOINC_EN
        exp_w1 = 8'h01;
        exp_w2 = 8'h02;
`else
        exp_w1 = 8'h02;
        exp_w2 = 8'h02;
`endif
        cmd(OP_SW, 8'(DEPTH - 1), 1'b1);
        cmd(OP_WR, 8'h01, 1'b1);
        cmd(OP_WR, 8'h02, 1'b1);
        cmd(OP_SR, 8'(DEPTH - 1), 1'b1);
        issue_read(exp_w1, 1'b1);
        expect_out("wrap1");
        issue_read(exp_w2, 1'b1);
        expect_out("wrap2");
        idle(1'b1);
        check("wrap.clear", 32'(tx_valid), 32'd0);

        // 6. reset while valid and a READ is presented
        cmd(OP_SR, 8'h10, 1'b0);
        issue_read(8'hA5, 1'b0);
        expect_out("prereset");
        rst_n = 1'b0;
        exp_q.delete();
        cmd(OP_RD, '0, 1'b0);
        check("reset2.valid", 32'(tx_valid), 32'd0);
        check("reset2.dout", 32'(dout), 32'h0);
        check("reset2.err", 32'(err), 32'd0);
        rst_n = 1'b1;
        cmd(OP_SR, 8'h10, 1'b1);
        issue_read(8'hA5, 1'b1);
        expect_out("postreset");
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
